// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types, beat stride and burst-length decode for the memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;
  localparam int STRIDE = 4;
  function automatic logic [4:0] burst_len(input logic [1:0] acc_size);
    return acc_size == 2'b00 ? 5'd1 : acc_size == 2'b01 ? 5'd4 : acc_size == 2'b10 ? 5'd8 : 5'd16;
  endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data and memory-side signals of the arbiter
interface mem_arbiter_if #(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE = 32,
  parameter int ACCESS_SIZE = 2
);
  logic if_req;
  logic [ADDRESS_SIZE-1:0] if_addr;
  logic [ACCESS_SIZE-1:0] if_acc_size;
  logic if_gnt;
  logic if_rvalid;
  logic [DATA_SIZE-1:0] if_rdata;
  logic if_done;
  logic d_req;
  logic [ADDRESS_SIZE-1:0] d_addr;
  logic [ACCESS_SIZE-1:0] d_acc_size;
  logic d_wren;
  logic [DATA_SIZE-1:0] d_wdata;
  logic d_gnt;
  logic d_wready;
  logic d_rvalid;
  logic [DATA_SIZE-1:0] d_rdata;
  logic d_done;
  logic [ADDRESS_SIZE-1:0] mem_addr;
  logic [DATA_SIZE-1:0] mem_d_in;
  logic [DATA_SIZE-1:0] mem_d_out;
  logic [ACCESS_SIZE-1:0] mem_acc_size;
  logic mem_wren;
  logic mem_enable;
  modport slave (
    input if_req, if_addr, if_acc_size, d_req, d_addr, d_acc_size, d_wren, d_wdata, mem_d_out,
    output if_gnt, if_rvalid, if_rdata, if_done, d_gnt, d_wready, d_rvalid, d_rdata, d_done,
    output mem_addr, mem_d_in, mem_acc_size, mem_wren, mem_enable
  );
  modport master (
    output if_req, if_addr, if_acc_size, d_req, d_addr, d_acc_size, d_wren, d_wdata, mem_d_out,
    input if_gnt, if_rvalid, if_rdata, if_done, d_gnt, d_wready, d_rvalid, d_rdata, d_done,
    input mem_addr, mem_d_in, mem_acc_size, mem_wren, mem_enable
  );
endinterface

// File: rtl/mem_arbiter_burst_counter.sv
// burst_counter: latches the burst length on grant, counts beats and flags the final one
module burst_counter
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [1:0] acc_size,
  output logic       last
);
  logic [4:0] cnt, len;
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      len <= '0;
    end else if (load) begin
      cnt <= '0;
      len <= burst_len(acc_size);
    end else if (en) cnt <= cnt + 5'd1;
  assign last = cnt == len - 5'd1;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter granting fetch/data bursts onto a single-word memory port
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE = 32,
  parameter int ACCESS_SIZE = 2
) (
  input logic clk,
  input logic rst,
  mem_arbiter_if.slave bus
);
  state_t state;
  owner_t owner;
  logic sel_d, beat_last;
  // owner doubles as last-served: data wins a tie only when fetch was served last
  assign sel_d = bus.d_req & (~bus.if_req | owner == OWN_IF);
  burst_counter u_cnt (
    .clk,
    .rst,
    .load(state == IDLE && (bus.if_req || bus.d_req)),
    .en(state == BURST),
    .acc_size(sel_d ? bus.d_acc_size : bus.if_acc_size),
    .last(beat_last)
  );
  assign bus.mem_acc_size = {ACCESS_SIZE{1'b0}};
  assign bus.d_wready = bus.mem_wren;
  assign bus.mem_d_in = bus.mem_wren ? bus.d_wdata : {DATA_SIZE{1'b0}};
  assign bus.if_rdata = bus.if_rvalid ? bus.mem_d_out : {DATA_SIZE{1'b0}};
  assign bus.d_rdata = bus.d_rvalid ? bus.mem_d_out : {DATA_SIZE{1'b0}};
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      owner <= OWN_D;
      bus.if_gnt <= 1'b0;
      bus.d_gnt <= 1'b0;
      bus.if_done <= 1'b0;
      bus.d_done <= 1'b0;
      bus.if_rvalid <= 1'b0;
      bus.d_rvalid <= 1'b0;
      bus.mem_enable <= 1'b0;
      bus.mem_wren <= 1'b0;
      bus.mem_addr <= '0;
    end else begin
      bus.if_gnt <= 1'b0;
      bus.d_gnt <= 1'b0;
      bus.if_done <= 1'b0;
      bus.d_done <= 1'b0;
      bus.if_rvalid <= bus.mem_enable && !bus.mem_wren && owner == OWN_IF;
      bus.d_rvalid <= bus.mem_enable && !bus.mem_wren && owner == OWN_D;
      case (state)
        IDLE:
          if (bus.if_req || bus.d_req) begin
            state <= BURST;
            owner <= sel_d ? OWN_D : OWN_IF;
            bus.if_gnt <= ~sel_d;
            bus.d_gnt <= sel_d;
            bus.mem_enable <= 1'b1;
            bus.mem_wren <= sel_d & bus.d_wren;
            bus.mem_addr <= sel_d ? bus.d_addr : bus.if_addr;
          end
        BURST:
          if (beat_last) begin
            state <= DRAIN;
            bus.mem_enable <= 1'b0;
            bus.mem_wren <= 1'b0;
            bus.mem_addr <= '0;
            bus.if_done <= owner == OWN_IF;
            bus.d_done <= owner == OWN_D;
          end else bus.mem_addr <= bus.mem_addr + ADDRESS_SIZE'(STRIDE);
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench against a busy-window reference model
module tb_mem_arbiter;
  typedef struct {
    int c;
    logic [31:0] a;
    logic w;
    logic [31:0] d;
  } ev_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  logic rst_edge = 1'b0;
  ev_t beat_q[$], ifr_q[$], dr_q[$], ifg_q[$], dg_q[$], ifd_q[$], dd_q[$];
  mem_arbiter_if bus ();
  mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  function automatic logic [31:0] wd(input int c);
    return (32'(c) * 32'h0100_0193) + 32'hC0DE_0000;
  endfunction

  // memory with one cycle of read latency; junk when not reading
  always @(posedge clk) bus.mem_d_out <= (bus.mem_enable && !bus.mem_wren) ? rd(bus.mem_addr) : $urandom;

  initial forever begin
    @(posedge clk);
    cyc++;
    rst_edge = rst;
    #1 bus.d_wdata = wd(cyc);
  end

  task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, exp);
    end
  endtask

  task automatic take(ref ev_t q[$], input logic fire, input string nm, output logic hit, output ev_t e);
    hit = 1'b0;
    e = '{0, 32'd0, 1'b0, 32'd0};
    while (q.size() > 0 && q[0].c < cyc) begin
      total++;
      bad++;
      $display("FAIL %s missing cyc=%0d got=0 want=1 (due cyc %0d)", nm, cyc, q[0].c);
      void'(q.pop_front());
    end
    if (fire) begin
      total++;
      if (q.size() == 0 || q[0].c != cyc) begin
        bad++;
        $display("FAIL %s unexpected cyc=%0d got=1 want=0", nm, cyc);
      end else begin
        hit = 1'b1;
        e = q.pop_front();
      end
    end
  endtask

  // monitor
  initial forever begin
    logic h;
    ev_t e;
    @(negedge clk);
    if (rst_edge) begin
      cmp("rst_ctl", 64'({bus.if_gnt, bus.d_gnt, bus.if_done, bus.d_done, bus.if_rvalid, bus.d_rvalid,
                          bus.d_wready, bus.mem_enable, bus.mem_wren, bus.mem_acc_size}), 64'd0);
      cmp("rst_addr", {bus.mem_addr, bus.mem_d_in}, 64'd0);
      cmp("rst_rdata", {bus.if_rdata, bus.d_rdata}, 64'd0);
    end
    take(beat_q, bus.mem_enable, "beat", h, e);
    if (h) begin
      cmp("mem_addr", 64'(bus.mem_addr), 64'(e.a));
      cmp("mem_wren", 64'({bus.mem_wren, bus.d_wready, bus.mem_acc_size}), 64'({e.w, e.w, 2'b00}));
      if (e.w) cmp("mem_d_in", 64'(bus.mem_d_in), 64'(e.d));
    end else if (!bus.mem_enable) cmp("idle_wr", 64'({bus.d_wready, bus.mem_wren}), 64'd0);
    take(ifr_q, bus.if_rvalid, "if_rvalid", h, e);
    if (h) cmp("if_rdata", 64'(bus.if_rdata), 64'(e.d));
    take(dr_q, bus.d_rvalid, "d_rvalid", h, e);
    if (h) cmp("d_rdata", 64'(bus.d_rdata), 64'(e.d));
    take(ifg_q, bus.if_gnt, "if_gnt", h, e);
    take(dg_q, bus.d_gnt, "d_gnt", h, e);
    take(ifd_q, bus.if_done, "if_done", h, e);
    take(dd_q, bus.d_done, "d_done", h, e);
  end

  // reference model: an owner holds the memory for N beats plus one drain cycle
  initial begin
    int lens[4] = '{1, 4, 8, 16};
    int free_c = 0;
    logic last_d = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        beat_q.delete(); ifr_q.delete(); dr_q.delete();
        ifg_q.delete(); dg_q.delete(); ifd_q.delete(); dd_q.delete();
        last_d = 1'b1;
        free_c = cyc + 1;
      end else if (cyc >= free_c && (bus.if_req || bus.d_req)) begin
        logic own_d, w;
        logic [31:0] base;
        int n, e0;
        own_d = bus.d_req && (!bus.if_req || !last_d);
        base = own_d ? bus.d_addr : bus.if_addr;
        n = lens[own_d ? int'(bus.d_acc_size) : int'(bus.if_acc_size)];
        w = own_d && bus.d_wren;
        e0 = cyc + 1;
        if (own_d) dg_q.push_back('{e0, 32'd0, 1'b0, 32'd0});
        else ifg_q.push_back('{e0, 32'd0, 1'b0, 32'd0});
        for (int k = 0; k < n; k++) begin
          logic [31:0] a;
          a = base + 32'(4 * k);
          beat_q.push_back('{e0 + k, a, w, wd(e0 + k)});
          if (!w && own_d) dr_q.push_back('{e0 + 1 + k, a, 1'b0, rd(a)});
          if (!own_d) ifr_q.push_back('{e0 + 1 + k, a, 1'b0, rd(a)});
        end
        if (own_d) dd_q.push_back('{e0 + n, 32'd0, 1'b0, 32'd0});
        else ifd_q.push_back('{e0 + n, 32'd0, 1'b0, 32'd0});
        last_d = own_d;
        free_c = e0 + n + 1;
      end
    end
  end

  task automatic fetch(input logic [31:0] a, input logic [1:0] s);
    logic got = 1'b0;
    @(posedge clk);
    #1;
    bus.if_req = 1'b1;
    bus.if_addr = a;
    bus.if_acc_size = s;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      got = bus.if_gnt;
    end
    cmp("if_gnt_wait", 64'(got), 64'd1);
    @(posedge clk);
    #1;
    bus.if_req = 1'b0;
    bus.if_addr = $urandom;
    bus.if_acc_size = 2'($urandom_range(0, 3));
  endtask

  task automatic data(input logic [31:0] a, input logic [1:0] s, input logic w);
    logic got = 1'b0;
    @(posedge clk);
    #1;
    bus.d_req = 1'b1;
    bus.d_addr = a;
    bus.d_acc_size = s;
    bus.d_wren = w;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      got = bus.d_gnt;
    end
    cmp("d_gnt_wait", 64'(got), 64'd1);
    @(posedge clk);
    #1;
    bus.d_req = 1'b0;
    bus.d_addr = $urandom;
    bus.d_acc_size = 2'($urandom_range(0, 3));
    bus.d_wren = 1'($urandom);
  endtask

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_acc_size = '0;
    bus.d_req = 1'b0; bus.d_addr = '0; bus.d_acc_size = '0; bus.d_wren = 1'b0;
    bus.d_wdata = '0; bus.mem_d_out = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    fetch(32'h8002_0000, 2'b01);
    fork
      fetch(32'h8002_0040, 2'b00);
      data(32'h8002_0100, 2'b10, 1'b1);
    join
    fork
      fetch(32'h0000_1000, 2'b01);
      data(32'hFFFF_FFF8, 2'b01, 1'b0);
    join
    fetch(32'h8002_0200, 2'b11);
    repeat (20) @(posedge clk);
    fetch(32'h8002_0400, 2'b11);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    fetch(32'h8002_0080, 2'b10);
    fork
      for (int i = 0; i < 20; i++) begin
        repeat ($urandom_range(0, 6)) @(posedge clk);
        fetch($urandom, 2'($urandom_range(0, 3)));
      end
      for (int j = 0; j < 20; j++) begin
        repeat ($urandom_range(0, 6)) @(posedge clk);
        data($urandom, 2'($urandom_range(0, 3)), 1'($urandom));
      end
    join
    repeat (60) @(posedge clk);
    @(negedge clk);
    #2;
    cmp("left_beats", 64'(beat_q.size()), 64'd0);
    cmp("left_rd", 64'(ifr_q.size() + dr_q.size()), 64'd0);
    cmp("left_gnt_done", 64'(ifg_q.size() + dg_q.size() + ifd_q.size() + dd_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDRESS_SIZE, default 32, address width; DATA_SIZE, default 32, data word width; ACCESS_SIZE, default 2, burst-size code width.
REQ-002 clk  in  1  single clock, all logic on posedge clk.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 if_req  in  1  fetch requester wants a read burst; if_addr  in  ADDRESS_SIZE  burst base address; if_acc_size  in  ACCESS_SIZE  burst size code.
REQ-005 if_gnt  out  1  one-cycle grant pulse; if_rvalid  out  1  read word valid; if_rdata  out  DATA_SIZE  read word; if_done  out  1  one-cycle burst-complete pulse.
REQ-006 d_req  in  1; d_addr  in  ADDRESS_SIZE; d_acc_size  in  ACCESS_SIZE; d_wren  in  1  write burst when 1; d_wdata  in  DATA_SIZE  write word for the current beat.
REQ-007 d_gnt  out  1; d_wready  out  1  d_wdata consumed this cycle; d_rvalid  out  1; d_rdata  out  DATA_SIZE; d_done  out  1.
REQ-008 mem_addr  out  ADDRESS_SIZE; mem_d_in  out  DATA_SIZE; mem_d_out  in  DATA_SIZE; mem_acc_size  out  ACCESS_SIZE  tied to 2'b00 (single word); mem_wren  out  1; mem_enable  out  1.

Function
REQ-009 Burst length N SHALL be 1, 4, 8, 16 words for acc_size 00, 01, 10, 11.
REQ-010 States SHALL be IDLE, BURST, DRAIN.
REQ-011 In IDLE with exactly one req high, that requester SHALL be selected; with both high, the requester not served last SHALL be selected (round-robin; last-served resets to data, so fetch wins the first tie).
REQ-012 On selection at edge t, addr, acc_size and wren (fetch: wren=0) SHALL be latched, the FSM enters BURST, and gnt pulses for cycle t+1 only.
REQ-013 In BURST beat k (k=0..N-1, cycles t+1..t+N) mem_enable SHALL be 1 and mem_addr SHALL be base+4k, modulo 2^ADDRESS_SIZE (wrap-around permitted, no alignment applied).
REQ-014 Write bursts: mem_wren=1, mem_d_in=d_wdata and d_wready=1 in every beat cycle; zero otherwise.
REQ-015 Read bursts: mem_wren=0; beat k word SHALL appear on the owner's rdata with rvalid=1 in cycle t+2+k (memory read latency 1); the non-owner's rvalid SHALL stay 0.
REQ-016 After beat N-1 the FSM SHALL enter DRAIN for exactly one cycle with mem_enable=0; the owner's done SHALL pulse in the DRAIN cycle (coincident with the last rvalid for reads).
REQ-017 From DRAIN the FSM SHALL return to IDLE; the next grant is at the earliest one cycle later (one idle cycle between bursts).
REQ-018 Deasserting req or changing addr/acc_size/wren during BURST/DRAIN SHALL have no effect; the latched burst completes.
REQ-019 A req held high through done SHALL be treated as a new request in IDLE.
REQ-020 Beat counter SHALL be 5 bits, cleared on grant, no overflow at N=16.

Reset
REQ-021 With rst=1 at a clock edge, state SHALL become IDLE, last-served SHALL become data, and every output (gnt, done, rvalid, rdata, wready, mem_enable, mem_wren, mem_addr, mem_d_in) SHALL be 0 from the next cycle.
REQ-022 Reset during BURST or DRAIN SHALL abort the burst with no further mem_enable beat and no done pulse.

Structure
REQ-023 Package mem_arb_pkg SHALL hold the state enum, the acc_size-to-N function, and the beat address stride constant (4).
REQ-024 One sub-module, burst_counter (load on grant, count beats, flag last beat), SHALL be used; all else in mem_arbiter.

Verification
REQ-025 Single fetch: if_req, if_addr=0x80020000, acc_size=01 -> if_gnt at t+1, mem_addr 0x80020000/04/08/0C at t+1..t+4, if_rvalid t+2..t+5, if_done at t+5.
REQ-026 Tie: if_req and d_req high together after reset -> fetch granted first; data granted one cycle after if_done; next tie -> fetch again.
REQ-027 Data write acc_size=10, d_addr=0x80020100 -> 8 cycles of mem_wren=1, d_wready=1, addresses 0x100..0x11C, d_done at DRAIN, no d_rvalid.
REQ-028 Wrap: d_addr=0xFFFFFFF8, acc_size=01, read -> mem_addr FFFFFFF8, FFFFFFFC, 00000000, 00000004.
REQ-029 rst asserted on beat 3 of a 16-beat read -> mem_enable 0 next cycle, no done, all outputs 0; new request served normally afterwards.
REQ-030 if_req dropped after grant with acc_size=11 -> all 16 beats and if_done still produced.
